// File: rtl/dbg_bus_arbiter.sv
// rtl/dbg_bus_arbiter.sv - shares the core memory bus with the JTAG debug module
//
// Optional feature macro: DBG_BUS_TIMEOUT_EN (bus-ack timeout on debug accesses)
//
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   dbg_op_req_i             level debug request, rising edge starts one access
//   dbg_we_i/addr_i/wdata_i  debug access fields, latched on the rising edge
//   dbg_halt_req_i           holds the core while high
//   dbg_rdata_o              read data of the last debug read
//   dbg_done_o               access complete, held until dbg_op_req_i drops
//   dbg_err_o                access timed out (0 unless DBG_BUS_TIMEOUT_EN)
//   core_*                   core-side bus port and pipeline hold
//   bus_*                    shared memory bus
module dbg_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] RDATA_ERR      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dbg_op_req_i,
    input  logic        dbg_we_i,
    input  logic [31:0] dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    input  logic        dbg_halt_req_i,
    output logic [31:0] dbg_rdata_o,
    output logic        dbg_done_o,
    output logic        dbg_err_o,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    output logic        core_ack_o,
    output logic [31:0] core_rdata_o,
    output logic        core_hold_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i
);

    localparam logic [1:0] ST_CORE          = 2'd0;
    localparam logic [1:0] ST_DRAIN         = 2'd1;
    localparam logic [1:0] ST_DBG_REQ       = 2'd2;
    localparam logic [1:0] ST_DBG_WAIT_DROP = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic        op_q;
    logic        rise;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        timeout;

    assign rise = dbg_op_req_i & ~op_q;

`ifdef DBG_BUS_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] to_cnt;

    // Fires in the last unacked DBG_REQ cycle, so the bus is requested for
    // exactly TIMEOUT_CYCLES cycles before being released.
    assign timeout = (state == ST_DBG_REQ) && !bus_ack_i &&
                     (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Held at zero outside DBG_REQ, which clears it on every DBG_REQ entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state != ST_DBG_REQ) begin
            to_cnt <= '0;
        end else if (!bus_ack_i) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_err_o <= 1'b0;
        end else if (state == ST_CORE && rise) begin
            dbg_err_o <= 1'b0;
        end else if (timeout) begin
            dbg_err_o <= 1'b1;
        end
    end
`else
    assign timeout   = 1'b0;
    assign dbg_err_o = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_CORE:          if (rise) state_next = ST_DRAIN;
            // Let an in-flight core transaction complete before taking the bus.
            ST_DRAIN:         if (!core_req_i || bus_ack_i) state_next = ST_DBG_REQ;
            ST_DBG_REQ:       if (bus_ack_i || timeout) state_next = ST_DBG_WAIT_DROP;
            ST_DBG_WAIT_DROP: if (!dbg_op_req_i) state_next = ST_CORE;
            default:          state_next = ST_CORE;
        endcase
    end

    always_comb begin
        bus_req_o    = core_req_i;
        bus_we_o     = core_we_i;
        bus_addr_o   = core_addr_i;
        bus_wdata_o  = core_wdata_i;
        core_ack_o   = bus_ack_i;
        core_rdata_o = bus_rdata_i;
        case (state)
            ST_DBG_REQ: begin
                bus_req_o   = 1'b1;
                bus_we_o    = lat_we;
                bus_addr_o  = lat_addr;
                bus_wdata_o = lat_wdata;
                core_ack_o  = 1'b0;
            end
            ST_DBG_WAIT_DROP: begin
                bus_req_o   = 1'b0;
                bus_we_o    = lat_we;
                bus_addr_o  = lat_addr;
                bus_wdata_o = lat_wdata;
                core_ack_o  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_CORE;
            op_q        <= 1'b0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            dbg_rdata_o <= '0;
            dbg_done_o  <= 1'b0;
            core_hold_o <= 1'b0;
        end else begin
            state <= state_next;
            op_q  <= dbg_op_req_i;
            // Built from the next state so the hold rises together with DRAIN.
            core_hold_o <= dbg_halt_req_i | (state_next != ST_CORE);

            // Rises outside CORE cannot happen by protocol and are ignored.
            if (state == ST_CORE && rise) begin
                lat_we    <= dbg_we_i;
                lat_addr  <= dbg_addr_i;
                lat_wdata <= dbg_wdata_i;
            end

            if (state == ST_DBG_REQ && bus_ack_i) begin
                dbg_done_o <= 1'b1;
                if (!lat_we) dbg_rdata_o <= bus_rdata_i;
            end else if (timeout) begin
                dbg_done_o  <= 1'b1;
                dbg_rdata_o <= RDATA_ERR;
            end

            if (state == ST_DBG_WAIT_DROP && !dbg_op_req_i) dbg_done_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dbg_bus_arbiter.sv
// tb/tb_dbg_bus_arbiter.sv - self-checking bench for dbg_bus_arbiter
module tb_dbg_bus_arbiter;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dbg_op_req = 1'b0;
    logic        dbg_we = 1'b0;
    logic [31:0] dbg_addr = '0;
    logic [31:0] dbg_wdata = '0;
    logic        dbg_halt_req = 1'b0;
    logic [31:0] dbg_rdata;
    logic        dbg_done;
    logic        dbg_err;
    logic        core_req = 1'b0;
    logic        core_we = 1'b0;
    logic [31:0] core_addr = '0;
    logic [31:0] core_wdata = '0;
    logic        core_ack;
    logic [31:0] core_rdata;
    logic        core_hold;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    xfer_t       exp_q[$];
    xfer_t       obs_q[$];
    logic [31:0] exp_rdata_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          slave_wait = 0;
    logic        slave_mute = 1'b0;
    logic [31:0] slave_rdata = '0;
    int          wait_cnt = 0;
    logic [31:0] last_dbg_rdata = '0;

    dbg_bus_arbiter #(.TIMEOUT_CYCLES(4), .RDATA_ERR(32'hDEAD_BEEF)) dut (
        .clk(clk), .rst(rst),
        .dbg_op_req_i(dbg_op_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
        .dbg_wdata_i(dbg_wdata), .dbg_halt_req_i(dbg_halt_req),
        .dbg_rdata_o(dbg_rdata), .dbg_done_o(dbg_done), .dbg_err_o(dbg_err),
        .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
        .core_wdata_i(core_wdata), .core_ack_o(core_ack), .core_rdata_o(core_rdata),
        .core_hold_o(core_hold),
        .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
        .bus_wdata_o(bus_wdata), .bus_rdata_i(bus_rdata), .bus_ack_i(bus_ack)
    );

    always #5 clk = ~clk;

    // Slave model: acks after slave_wait request cycles, or never when muted.
    assign bus_ack   = bus_req && !slave_mute && (wait_cnt >= slave_wait);
    assign bus_rdata = bus_ack ? slave_rdata : 32'h0;

    always @(posedge clk) begin
        if (bus_req && !bus_ack) wait_cnt <= wait_cnt + 1;
        else                     wait_cnt <= 0;
        if (bus_ack) obs_q.push_back({bus_we, bus_addr, bus_wdata});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (dbg_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", dbg_rdata); end
        n_checks++; if (dbg_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", dbg_done); end
        n_checks++; if (dbg_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", dbg_err); end
        n_checks++; if (core_hold !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got %b want 0", core_hold); end
        n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_dbg_read();
        xfer_t e, o;
        logic [31:0] er;
        slave_wait = 0; slave_rdata = 32'h1234_5678;
        exp_q.push_back({1'b0, 32'h0000_0100, 32'h0});
        exp_rdata_q.push_back(32'h1234_5678);
        dbg_we = 1'b0; dbg_addr = 32'h0000_0100; dbg_wdata = 32'h0; dbg_op_req = 1'b1;
        @(negedge clk); // N+1: DRAIN
        n_checks++; if (core_hold !== 1'b1) begin n_fail++; $display("FAIL rd_hold_n1: got %b want 1", core_hold); end
        n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL rd_req_n1: got %b want 0", bus_req); end
        @(negedge clk); // N+2: DBG_REQ
        n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL rd_req_n2: got %b want 1", bus_req); end
        n_checks++; if (dbg_done !== 1'b0) begin n_fail++; $display("FAIL rd_done_n2: got %b want 0", dbg_done); end
        @(negedge clk); // N+3: done
        er = exp_rdata_q.pop_front();
        n_checks++; if (dbg_done !== 1'b1) begin n_fail++; $display("FAIL rd_done_n3: got %b want 1", dbg_done); end
        n_checks++; if (dbg_rdata !== er) begin n_fail++; $display("FAIL rd_rdata: got %h want %h", dbg_rdata, er); end
        n_checks++; if (core_hold !== 1'b1) begin n_fail++; $display("FAIL rd_hold_n3: got %b want 1", core_hold); end
        last_dbg_rdata = er;
        dbg_op_req = 1'b0;
        @(negedge clk);
        n_checks++; if (dbg_done !== 1'b0) begin n_fail++; $display("FAIL rd_done_drop: got %b want 0", dbg_done); end
        n_checks++; if (core_hold !== 1'b0) begin n_fail++; $display("FAIL rd_hold_drop: got %b want 0", core_hold); end
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rd_xfer_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL rd_xfer: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_drain_write();
        xfer_t e, o;
        int    core_acks = 0;
        bit    drop_next = 0;
        bit    done_seen = 0;
        logic  ack_now, done_now;
        slave_wait = 3; slave_rdata = 32'hCAFE_0001;
        exp_q.push_back({1'b0, 32'h0000_0300, 32'h0});
        exp_q.push_back({1'b1, 32'h0000_0200, 32'hA5A5_A5A5});
        core_we = 1'b0; core_addr = 32'h0000_0300; core_wdata = 32'h0; core_req = 1'b1;
        @(negedge clk);
        dbg_we = 1'b1; dbg_addr = 32'h0000_0200; dbg_wdata = 32'hA5A5_A5A5; dbg_op_req = 1'b1;
        for (int i = 0; i < 30 && !done_seen; i++) begin
            @(negedge clk);
            ack_now = core_ack; done_now = dbg_done;
            if (ack_now) begin
                core_acks++;
                n_checks++; if (core_rdata !== 32'hCAFE_0001) begin n_fail++; $display("FAIL dw_core_rdata: got %h want cafe0001", core_rdata); end
                n_checks++; if (done_now !== 1'b0) begin n_fail++; $display("FAIL dw_core_first: done %b want 0", done_now); end
            end
            if (done_now) done_seen = 1;
            if (drop_next) begin core_req = 1'b0; drop_next = 0; end
            if (ack_now) drop_next = 1;
        end
        n_checks++; if (!done_seen) begin n_fail++; $display("FAIL dw_done_timeout: got 0 want 1"); end
        n_checks++; if (core_acks != 1) begin n_fail++; $display("FAIL dw_core_acks: got %0d want 1", core_acks); end
        n_checks++; if (dbg_rdata !== last_dbg_rdata) begin n_fail++; $display("FAIL dw_rdata_kept: got %h want %h", dbg_rdata, last_dbg_rdata); end
        core_req = 1'b0;
        dbg_op_req = 1'b0;
        @(negedge clk);
        n_checks++; if (dbg_done !== 1'b0) begin n_fail++; $display("FAIL dw_done_drop: got %b want 0", dbg_done); end
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL dw_xfer_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL dw_xfer: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_pulse();
        xfer_t e, o;
        int          done_cycles = 0;
        bit          got = 0;
        logic [31:0] rd = '0;
        logic [31:0] er;
        slave_wait = 0; slave_rdata = 32'h0BAD_F00D;
        exp_q.push_back({1'b0, 32'h0000_0104, 32'h0});
        exp_rdata_q.push_back(32'h0BAD_F00D);
        dbg_we = 1'b0; dbg_addr = 32'h0000_0104; dbg_wdata = 32'h0; dbg_op_req = 1'b1;
        @(negedge clk);
        dbg_op_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (dbg_done) begin
                done_cycles++;
                if (!got) begin got = 1; rd = dbg_rdata; end
            end
        end
        er = exp_rdata_q.pop_front();
        n_checks++; if (done_cycles != 1) begin n_fail++; $display("FAIL pulse_done_cycles: got %0d want 1", done_cycles); end
        n_checks++; if (rd !== er) begin n_fail++; $display("FAIL pulse_rdata: got %h want %h", rd, er); end
        n_checks++; if (core_hold !== 1'b0) begin n_fail++; $display("FAIL pulse_back_to_core: hold %b want 0", core_hold); end
        last_dbg_rdata = er;
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL pulse_xfer_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL pulse_xfer: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_halt();
        xfer_t e, o;
        bit acked = 0;
        dbg_halt_req = 1'b1;
        @(negedge clk);
        n_checks++; if (core_hold !== 1'b1) begin n_fail++; $display("FAIL halt_hold: got %b want 1", core_hold); end
        slave_wait = 1; slave_rdata = 32'h0;
        exp_q.push_back({1'b1, 32'h0000_0400, 32'h0000_0055});
        core_we = 1'b1; core_addr = 32'h0000_0400; core_wdata = 32'h0000_0055; core_req = 1'b1;
        #1;
        n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL halt_req_follow: got %b want 1", bus_req); end
        n_checks++; if (bus_addr !== 32'h0000_0400) begin n_fail++; $display("FAIL halt_addr: got %h want 00000400", bus_addr); end
        for (int i = 0; i < 10 && !acked; i++) begin
            @(negedge clk);
            if (core_ack) acked = 1;
        end
        n_checks++; if (!acked) begin n_fail++; $display("FAIL halt_core_ack: got 0 want 1"); end
        @(negedge clk);
        core_req = 1'b0;
        #1;
        n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL halt_req_drop: got %b want 0", bus_req); end
        dbg_halt_req = 1'b0;
        @(negedge clk);
        n_checks++; if (core_hold !== 1'b0) begin n_fail++; $display("FAIL halt_release: got %b want 0", core_hold); end
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL halt_xfer_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL halt_xfer: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        xfer_t e, o;
        slave_mute = 1'b1;
        dbg_we = 1'b0; dbg_addr = 32'h0000_0108; dbg_wdata = 32'h0; dbg_op_req = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_req_before: got %b want 1", bus_req); end
        rst = 1'b1; dbg_op_req = 1'b0;
        @(negedge clk);
        n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req: got %b want 0", bus_req); end
        n_checks++; if (core_hold !== 1'b0) begin n_fail++; $display("FAIL rstmid_hold: got %b want 0", core_hold); end
        n_checks++; if (dbg_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", dbg_done); end
        n_checks++; if (dbg_rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_rdata: got %h want 0", dbg_rdata); end
        rst = 1'b0; slave_mute = 1'b0; last_dbg_rdata = 32'h0;
        @(negedge clk);
        slave_wait = 0; slave_rdata = 32'h0000_0077;
        exp_q.push_back({1'b0, 32'h0000_0500, 32'h0});
        core_we = 1'b0; core_addr = 32'h0000_0500; core_wdata = 32'h0; core_req = 1'b1;
        #1;
        n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_core_req: got %b want 1", bus_req); end
        n_checks++; if (core_ack !== 1'b1) begin n_fail++; $display("FAIL rstmid_core_ack: got %b want 1", core_ack); end
        n_checks++; if (core_rdata !== 32'h0000_0077) begin n_fail++; $display("FAIL rstmid_core_rdata: got %h want 00000077", core_rdata); end
        @(negedge clk);
        core_req = 1'b0;
        @(negedge clk);
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rstmid_xfer_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL rstmid_xfer: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

`ifdef DBG_BUS_TIMEOUT_EN
    task automatic test_timeout();
        xfer_t e, o;
        int          req_cycles = 0;
        bit          done_seen = 0;
        logic [31:0] er;
        slave_mute = 1'b1;
        exp_rdata_q.push_back(32'hDEAD_BEEF);
        dbg_we = 1'b0; dbg_addr = 32'h0000_010C; dbg_wdata = 32'h0; dbg_op_req = 1'b1;
        for (int i = 0; i < 20 && !done_seen; i++) begin
            @(negedge clk);
            if (bus_req) req_cycles++;
            if (dbg_done) done_seen = 1;
        end
        er = exp_rdata_q.pop_front();
        n_checks++; if (!done_seen) begin n_fail++; $display("FAIL to_done: got 0 want 1"); end
        n_checks++; if (req_cycles != 4) begin n_fail++; $display("FAIL to_req_cycles: got %0d want 4", req_cycles); end
        n_checks++; if (dbg_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", dbg_err); end
        n_checks++; if (dbg_rdata !== er) begin n_fail++; $display("FAIL to_rdata: got %h want %h", dbg_rdata, er); end
        dbg_op_req = 1'b0; slave_mute = 1'b0;
        @(negedge clk);
        n_checks++; if (core_hold !== 1'b0) begin n_fail++; $display("FAIL to_release: hold %b want 0", core_hold); end
        n_checks++; if (dbg_err !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky: got %b want 1", dbg_err); end
        slave_wait = 0; slave_rdata = 32'h1111_2222;
        exp_q.push_back({1'b0, 32'h0000_0110, 32'h0});
        dbg_addr = 32'h0000_0110; dbg_op_req = 1'b1;
        @(negedge clk);
        n_checks++; if (dbg_err !== 1'b0) begin n_fail++; $display("FAIL to_err_clear: got %b want 0", dbg_err); end
        repeat (3) @(negedge clk);
        n_checks++; if (dbg_rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL to_next_rdata: got %h want 11112222", dbg_rdata); end
        dbg_op_req = 1'b0;
        @(negedge clk);
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL to_xfer_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL to_xfer: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_dbg_read();
        test_drain_write();
        test_pulse();
        test_halt();
        test_reset_mid();
`ifdef DBG_BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
